matrix_inverse_gj: RTL and testbench

//  Parametrised NxN fixed-point matrix inverter: Gauss-Jordan with partial pivoting on an

---
 rtl/matrix_inverse_gj.sv | 264 ++++++++++++++++++++++++++
 tb/tb_matrix_inverse_gj.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_inverse_gj.sv
`default_nettype none
// ============================================================================
// Module   : matrix_inverse_gj
// Brief    : NxN fixed-point Gauss-Jordan inverter with partial pivoting,
//            one multiply-accumulate per cycle, streamed in/out row-major.
// Revision : 1.0
// ============================================================================
module matrix_inverse_gj #(
    parameter int N    = 5,
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         singular
);
    localparam int RW = $clog2(N);
    localparam int JW = $clog2(2*N);
    localparam int QW = 2*FRAC + 1;
    localparam int DW = $clog2(QW + 1);
    localparam int QX = ((QW > W) ? QW : W) + 1;

    localparam logic signed [W-1:0] c_ONE  = W'(1 << FRAC);
    localparam logic signed [W-1:0] c_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] c_MIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [2*W:0] c_HI   = {{(W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W:0] c_LO   = {{(W+2){1'b1}}, {(W-1){1'b0}}};
    localparam logic [QX-1:0]       c_QMAX = {{(QX-W+1){1'b0}}, {(W-1){1'b1}}};

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_PIV   = 3'd1,
        S_SWAP  = 3'd2,
        S_RECIP = 3'd3,
        S_NORM  = 3'd4,
        S_ELIM  = 3'd5,
        S_OUT   = 3'd6
    } state_t;

    state_t              r_state;
    logic signed [W-1:0] r_a [N][2*N];
    logic [RW-1:0]       r_k, r_i, r_piv;
    logic [JW-1:0]       r_j;
    logic [DW-1:0]       r_dc;
    logic [W:0]          r_max, r_rem;
    logic [QW-2:0]       r_q;
    logic signed [W-1:0] r_recip, r_f;
    logic                r_lat, r_in_ready, r_out_valid, r_out_last, r_singular;
    logic [W-1:0]        r_out_data;

    function automatic logic signed [W-1:0] f_sat(input logic signed [2*W:0] v);
        if (v > c_HI) return c_MAX;
        if (v < c_LO) return c_MIN;
        return v[W-1:0];
    endfunction

    // Full-precision product, floor-shifted back to Q format, then clamped.
    function automatic logic signed [W-1:0] f_mul(input logic signed [W-1:0] x,
                                                  input logic signed [W-1:0] y);
        logic signed [2*W-1:0] p;
        p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
        p = p >>> FRAC;
        return f_sat({p[2*W-1], p});
    endfunction

    function automatic logic signed [W-1:0] f_sub(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
        logic signed [2*W:0] d;
        d = $signed({{(W+1){a[W-1]}}, a}) - $signed({{(W+1){b[W-1]}}, b});
        return f_sat(d);
    endfunction

    logic signed [W-1:0] w_piv_elem, w_pivot, w_mul_y, w_mul, w_sub, w_qsat, w_recip;
    logic [W:0]          w_abs, w_pabs;
    logic [W+1:0]        w_trial;
    logic                w_ge, w_rows_done;
    logic [QW-1:0]       w_qn;
    logic [QX-1:0]       w_qx;
    logic [RW:0]         w_i1, w_inext;

    always_comb begin
        w_piv_elem = r_a[r_i][JW'(r_k)];
        w_abs      = w_piv_elem[W-1] ? -{w_piv_elem[W-1], w_piv_elem}
                                     :  {w_piv_elem[W-1], w_piv_elem};
        w_pivot    = r_a[r_k][JW'(r_k)];
        w_pabs     = w_pivot[W-1] ? -{w_pivot[W-1], w_pivot} : {w_pivot[W-1], w_pivot};
        // Dividend is 1 << 2*FRAC, so only the first shifted-in bit is a one.
        w_trial    = {r_rem, (r_dc == '0)};
        w_ge       = (w_trial >= {1'b0, w_pabs});
        w_qn       = {r_q, w_ge};
        w_qx       = {{(QX-QW){1'b0}}, w_qn};
        w_qsat     = (w_qx > c_QMAX) ? c_MAX : w_qx[W-1:0];
        w_recip    = w_pivot[W-1] ? -w_qsat : w_qsat;
        w_mul_y    = (r_state == S_NORM) ? r_recip : r_f;
        w_mul      = f_mul(r_a[r_k][r_j], w_mul_y);
        w_sub      = f_sub(r_a[r_i][r_j], w_mul);
        w_i1       = {1'b0, r_i} + (RW+1)'(1);
        w_inext    = (w_i1 == {1'b0, r_k}) ? w_i1 + (RW+1)'(1) : w_i1;
        w_rows_done = (w_inext >= (RW+1)'(N));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_LOAD;
            r_k         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_piv       <= '0;
            r_dc        <= '0;
            r_max       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_recip     <= '0;
            r_f         <= '0;
            r_lat       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_singular  <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: if (in_valid && r_in_ready) begin
                    r_a[r_i][r_j]           <= in_data;
                    r_a[r_i][r_j + JW'(N)]  <= (JW'(r_i) == r_j) ? c_ONE : '0;
                    r_singular              <= 1'b0;
                    if (r_j == JW'(N-1)) begin
                        r_j <= '0;
                        if (r_i == RW'(N-1)) begin
                            r_i        <= '0;
                            r_k        <= '0;
                            r_max      <= '0;
                            r_piv      <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= S_PIV;
                        end else begin
                            r_i <= r_i + RW'(1);
                        end
                    end else begin
                        r_j <= r_j + JW'(1);
                    end
                end
                S_PIV: begin
                    // Strict compare keeps the lowest row index on ties.
                    if (w_abs > r_max) begin
                        r_max <= w_abs;
                        r_piv <= r_i;
                    end
                    if (r_i == RW'(N-1)) begin
                        if (w_abs == '0 && r_max == '0) begin
                            r_singular <= 1'b1;
                            r_in_ready <= 1'b1;
                            r_i        <= '0;
                            r_j        <= '0;
                            r_state    <= S_LOAD;
                        end else begin
                            r_state <= S_SWAP;
                        end
                    end else begin
                        r_i <= r_i + RW'(1);
                    end
                end
                S_SWAP: begin
                    r_a[r_k]   <= r_a[r_piv];
                    r_a[r_piv] <= r_a[r_k];
                    r_dc       <= '0;
                    r_rem      <= '0;
                    r_q        <= '0;
                    r_state    <= S_RECIP;
                end
                S_RECIP: begin
                    r_rem <= (W+1)'(w_ge ? (w_trial - {1'b0, w_pabs}) : w_trial);
                    r_q   <= w_qn[QW-2:0];
                    if (r_dc == DW'(QW-1)) begin
                        r_recip <= w_recip;
                        r_j     <= '0;
                        r_state <= S_NORM;
                    end else begin
                        r_dc <= r_dc + DW'(1);
                    end
                end
                S_NORM: begin
                    r_a[r_k][r_j] <= w_mul;
                    if (r_j == JW'(2*N-1)) begin
                        r_j     <= '0;
                        r_i     <= (r_k == '0) ? RW'(1) : '0;
                        r_lat   <= 1'b1;
                        r_state <= S_ELIM;
                    end else begin
                        r_j <= r_j + JW'(1);
                    end
                end
                S_ELIM: begin
                    if (r_lat) begin
                        // Factor is latched because column k of this row gets overwritten.
                        r_f   <= w_piv_elem;
                        r_lat <= 1'b0;
                        r_j   <= '0;
                    end else begin
                        r_a[r_i][r_j] <= w_sub;
                        if (r_j == JW'(2*N-1)) begin
                            r_j   <= '0;
                            r_lat <= 1'b1;
                            if (w_rows_done) begin
                                if (r_k == RW'(N-1)) begin
                                    r_i     <= '0;
                                    r_state <= S_OUT;
                                end else begin
                                    r_k     <= r_k + RW'(1);
                                    r_i     <= r_k + RW'(1);
                                    r_piv   <= r_k + RW'(1);
                                    r_max   <= '0;
                                    r_state <= S_PIV;
                                end
                            end else begin
                                r_i <= w_inext[RW-1:0];
                            end
                        end else begin
                            r_j <= r_j + JW'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (r_out_valid && out_ready && r_out_last) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_i         <= '0;
                        r_j         <= '0;
                        r_state     <= S_LOAD;
                    end else if (!r_out_valid || out_ready) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_a[r_i][r_j + JW'(N)];
                        r_out_last  <= (r_i == RW'(N-1)) && (r_j == JW'(N-1));
                        if (r_j == JW'(N-1)) begin
                            r_j <= '0;
                            r_i <= r_i + RW'(1);
                        end else begin
                            r_j <= r_j + JW'(1);
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = ~r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign singular  = r_singular;

endmodule
`default_nettype wire

// File: tb/tb_matrix_inverse_gj.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_inverse_gj
// Brief    : Directed and random matrices checked against an arithmetic
//            Gauss-Jordan reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_matrix_inverse_gj;
    localparam int N    = 5;
    localparam int W    = 16;
    localparam int FRAC = 8;
    localparam int NN   = N*N;
    localparam longint c_VMAX = (64'sd1 <<< (W-1)) - 1;
    localparam longint c_VMIN = -(64'sd1 <<< (W-1));

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, out_valid, out_ready, out_last, busy, singular;
    logic [W-1:0] in_data, out_data;

    always #5 clk = ~clk;

    matrix_inverse_gj #(.N(N), .W(W), .FRAC(FRAC)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .singular  (singular)
    );

    int     n_chk  = 0;
    int     n_pass = 0;
    int     mat [NN];
    longint exp_inv [NN];
    bit     exp_sing;
    longint ma [N][2*N];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint sat(input longint v);
        if (v > c_VMAX) return c_VMAX;
        if (v < c_VMIN) return c_VMIN;
        return v;
    endfunction

    function automatic longint fmul(input longint x, input longint y);
        return sat((x * y) >>> FRAC);
    endfunction

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic ref_model();
        longint best, p, q, f, t;
        int     pr;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 2*N; j++)
                ma[i][j] = (j < N) ? longint'(mat[i*N+j]) : ((j - N == i) ? (64'sd1 <<< FRAC) : 0);
        exp_sing = 1'b0;
        for (int k = 0; k < N; k++) begin
            pr = k;
            best = labs(ma[k][k]);
            for (int r = k + 1; r < N; r++)
                if (labs(ma[r][k]) > best) begin best = labs(ma[r][k]); pr = r; end
            if (best == 0) begin exp_sing = 1'b1; return; end
            for (int j = 0; j < 2*N; j++) begin
                t = ma[k][j]; ma[k][j] = ma[pr][j]; ma[pr][j] = t;
            end
            p = ma[k][k];
            q = (64'sd1 <<< (2*FRAC)) / labs(p);
            if (q > c_VMAX) q = c_VMAX;
            if (p < 0) q = -q;
            for (int j = 0; j < 2*N; j++) ma[k][j] = fmul(ma[k][j], q);
            for (int i = 0; i < N; i++) begin
                if (i == k) continue;
                f = ma[i][k];
                for (int j = 0; j < 2*N; j++) ma[i][j] = sat(ma[i][j] - fmul(f, ma[k][j]));
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_inv[i*N+j] = ma[i][N+j];
    endtask

    task automatic send(input bit gaps);
        int idx = 0;
        int cyc = 0;
        bit fire;
        while (idx < NN && cyc < 2000) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = W'(mat[idx]);
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) begin
                idx++;
                if (idx == 1) chk("sing_clear", singular, 0);
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk("load_cnt", idx, NN);
        chk("busy_load", busy, 1);
        chk("rdy_load", in_ready, 0);
    endtask

    task automatic recv(input int mode);
        int           got = 0;
        int           cyc = 0;
        bit           stall = 1'b0;
        logic [W-1:0] pd = '0;
        logic         pl = 1'b0;
        while (got < NN && cyc < 5000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            @(negedge clk);
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, pd);
                chk("stall_last", out_last, pl);
            end
            if (out_valid && out_ready) begin
                chk("elem", $signed(out_data), exp_inv[got]);
                chk("last", out_last, (got == NN-1) ? 1 : 0);
                got++;
            end
            stall = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        chk("out_cnt", got, NN);
        chk("ret_ready", in_ready, 1);
        chk("ret_valid", out_valid, 0);
        chk("ret_sing", singular, 0);
    endtask

    task automatic wait_sing();
        int cyc = 0;
        int seen = 0;
        while (!in_ready && cyc < 3000) begin
            @(negedge clk);
            if (out_valid) seen++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("sing_ready", in_ready, 1);
        chk("sing_flag", singular, 1);
        chk("sing_noout", seen, 0);
    endtask

    task automatic run_case(input bit gaps, input int mode);
        ref_model();
        send(gaps);
        if (exp_sing) wait_sing();
        else recv(mode);
    endtask

    task automatic set_diag(input int d0, input int d1, input int d2, input int d3, input int d4);
        int d [N];
        d = '{d0, d1, d2, d3, d4};
        for (int i = 0; i < NN; i++) mat[i] = 0;
        for (int i = 0; i < N; i++) mat[i*N+i] = d[i];
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sing", singular, 0);
        reset = 1'b0;

        set_diag(256, 256, 256, 256, 256);
        run_case(1'b0, 0);

        set_diag(32'h0200, 32'h0400, 32'h0080, 32'h0100, -256);
        ref_model();
        chk("diag_model", exp_inv[2*N+2], 32'h0200);
        run_case(1'b0, 0);

        set_diag(0, 256, 256, 256, 0);
        mat[0*N+4] = 256;
        mat[4*N+0] = 256;
        run_case(1'b1, 0);

        for (int i = 0; i < NN; i++) mat[i] = int'($urandom_range(0, 1023)) - 512;
        for (int j = 0; j < N; j++) mat[2*N+j] = 0;
        run_case(1'b0, 0);

        set_diag(32'h0200, 32'h0400, 32'h0080, 32'h0100, -256);
        run_case(1'b0, 2);

        set_diag(256, 256, 256, 256, 256);
        send(1'b0);
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        reset = 1'b0;
        run_case(1'b0, 0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NN; i++)
                mat[i] = (t % 2 == 1) ? int'($urandom_range(0, 6)) - 3
                                      : int'($urandom_range(0, 2047)) - 1024;
            run_case(1'b1, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
